// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding and default debounce length for key_pulse_gen
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int KEY_STABLE_SIM = 4;

endpackage

// File: rtl/key_debounce_cell.sv
// rtl/key_debounce_cell.sv - one key channel: 2-flop synchroniser, debounce FSM, stability counter
module key_debounce_cell
    import key_pkg::*;
#(
    parameter int STABLE_CYCLES = KEY_STABLE_SIM
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic pulse,
    output logic level
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic           sync1;
    logic           s;
    key_state_t     state;
    key_state_t     state_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            sync1 <= key_raw;
            s     <= sync1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // pulse marks the PRESS_WAIT->PRESSED edge; the top registers it so it
    // appears in the first cycle spent in PRESSED
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse     = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    pulse     = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign level = (state == PRESSED) || (state == RELEASE_WAIT);

endmodule

// File: rtl/key_pulse_gen.sv
// rtl/key_pulse_gen.sv - two debounced key channels producing single-cycle en/clr pulses for counter
module key_pulse_gen
    import key_pkg::*;
#(
    parameter int STABLE_CYCLES = KEY_STABLE_SIM
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_en_raw,
    input  logic       key_clr_raw,
    output logic       en,
    output logic       clr,
    output logic [1:0] pressed
);

    logic pulse_en;
    logic pulse_clr;
    logic level_en;
    logic level_clr;

    key_debounce_cell #(.STABLE_CYCLES(STABLE_CYCLES)) u_cell_en (
        .clk     (clk),
        .reset   (reset),
        .key_raw (key_en_raw),
        .pulse   (pulse_en),
        .level   (level_en)
    );

    key_debounce_cell #(.STABLE_CYCLES(STABLE_CYCLES)) u_cell_clr (
        .clk     (clk),
        .reset   (reset),
        .key_raw (key_clr_raw),
        .pulse   (pulse_clr),
        .level   (level_clr)
    );

    // clear wins in counter anyway, so a coincident count pulse is simply dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            en  <= 1'b0;
            clr <= 1'b0;
        end else begin
            en  <= pulse_en & ~pulse_clr;
            clr <= pulse_clr;
        end
    end

    assign pressed = {level_clr, level_en};

endmodule
